// File: rtl/credit_tx_port.sv
// credit_tx_port: credit-based link transmitter with a staging FIFO and packet tracking.
//   CLK/RST              clock, asynchronous active-high reset
//   in_valid/in_ready    crossbar handshake; in_flit accepted when both are high
//   credit_return        one-cycle pulse: downstream freed CREDIT_CHUNK entries
//   out_wen/out_flit     registered write to the downstream buffer
//   credits              free downstream entries
//   pkt_active           head sent, tail not yet sent
//   credit_err           sticky credit overflow
package chiplet_types_pkg;
  typedef struct packed {
    logic [31:0] payload;
  } flit_t;
  // Packet length lives in the low nibble of the head payload; 0 means a single flit.
  function automatic logic [4:0] expected_num_flits(input logic [31:0] payload);
    logic [4:0] n;
    n = 5'(payload % 32'd16);
    return (n == 5'd0) ? 5'd1 : n;
  endfunction
endpackage

module credit_tx_port
  import chiplet_types_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CREDIT_CHUNK = 3 * DEPTH / 4,
  parameter int TX_DEPTH     = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  flit_t                      in_flit,
  input  logic                       credit_return,
  output logic                       out_wen,
  output flit_t                      out_flit,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic                       pkt_active,
  output logic                       credit_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int NW = $clog2(TX_DEPTH + 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  flit_t          mem_q [TX_DEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [NW-1:0]  cnt_q;
  logic [CW-1:0]  credits_q, credits_d;
  logic [SW-1:0]  credit_sum;
  logic           credit_err_q, credit_err_d;
  state_t         state_q;
  logic [4:0]     remaining_q;
  logic           out_wen_q, pkt_active_q;
  flit_t          out_flit_q;
  logic           full, empty, push, send;
  flit_t          head;
  logic [4:0]     head_len;
  assign full       = cnt_q == NW'(TX_DEPTH);
  assign empty      = cnt_q == '0;
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign send       = !empty && credits_q != '0;
  assign head       = mem_q[rptr_q];
  assign head_len   = expected_num_flits(head.payload);
  assign out_wen    = out_wen_q;
  assign out_flit   = out_flit_q;
  assign credits    = credits_q;
  assign pkt_active = pkt_active_q;
  assign credit_err = credit_err_q;
  // One extra bit so an over-return is visible before saturating.
  always_comb begin
    credit_sum   = {1'b0, credits_q} - SW'(send) + (credit_return ? SW'(CREDIT_CHUNK) : SW'(0));
    credits_d    = (credit_sum > SW'(DEPTH)) ? CW'(DEPTH) : credit_sum[CW-1:0];
    credit_err_d = credit_err_q || (credit_sum > SW'(DEPTH));
  end
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= in_flit;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      credits_q    <= CW'(DEPTH);
      credit_err_q <= 1'b0;
      out_wen_q    <= 1'b0;
      out_flit_q   <= '0;
      pkt_active_q <= 1'b0;
      state_q      <= IDLE;
      remaining_q  <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == PW'(TX_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (send) rptr_q <= (rptr_q == PW'(TX_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      cnt_q        <= cnt_q + NW'(push) - NW'(send);
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      out_wen_q    <= send;
      if (send) begin
        out_flit_q <= head;
        if (state_q == IDLE) begin
          remaining_q  <= head_len - 5'd1;
          state_q      <= (head_len == 5'd1) ? IDLE : ACTIVE;
          pkt_active_q <= head_len != 5'd1;
        end else begin
          remaining_q  <= remaining_q - 5'd1;
          state_q      <= (remaining_q == 5'd1) ? IDLE : ACTIVE;
          pkt_active_q <= remaining_q != 5'd1;
        end
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (push && full) $warning("credit_tx_port: staging FIFO overrun");
    if (send && empty) $warning("credit_tx_port: staging FIFO underrun");
  end
endmodule

// File: tb/tb_credit_tx_port.sv
// tb_credit_tx_port: randomized check of credit_tx_port against a queue-based reference model.
module tb_credit_tx_port;
  import chiplet_types_pkg::*;
  logic CLK = 1'b0, RST = 1'b1, in_valid = 1'b0, credit_return = 1'b0;
  flit_t in_flit = '0;
  logic in_ready, out_wen, pkt_active, credit_err;
  flit_t out_flit;
  logic [3:0] credits;
  int checks = 0, errors = 0;
  flit_t q[$];
  int m_cr, m_rem;
  bit m_err, m_wen;
  logic [31:0] m_flit;
  credit_tx_port #(.DEPTH(8), .CREDIT_CHUNK(6), .TX_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .credit_return(credit_return), .out_wen(out_wen), .out_flit(out_flit),
    .credits(credits), .pkt_active(pkt_active), .credit_err(credit_err)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  function automatic int plen(input logic [31:0] p);
    int n;
    n = int'(p % 32'd16);
    return (n == 0) ? 1 : n;
  endfunction
  task automatic model_reset();
    q.delete();
    m_cr = 8; m_rem = 0; m_err = 0; m_wen = 0; m_flit = '0;
  endtask
  task automatic model_edge();
    bit push, send;
    int nc;
    flit_t f;
    push = in_valid && q.size() < 4;
    send = q.size() > 0 && m_cr > 0;
    m_wen = send;
    if (send) begin
      f = q.pop_front();
      m_flit = f.payload;
      if (m_rem == 0) m_rem = plen(f.payload) - 1;
      else m_rem--;
    end
    nc = m_cr - int'(send) + (credit_return ? 6 : 0);
    if (nc > 8) begin
      nc = 8;
      m_err = 1;
    end
    m_cr = nc;
    if (push) q.push_back(in_flit);
  endtask
  task automatic check_all();
    chk("out_wen", 64'(out_wen), 64'(m_wen));
    chk("out_flit", 64'(out_flit.payload), 64'(m_flit));
    chk("credits", 64'(credits), 64'(m_cr));
    chk("pkt_active", 64'(pkt_active), 64'(m_rem != 0));
    chk("credit_err", 64'(credit_err), 64'(m_err));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 4));
  endtask
  task automatic step(input bit v, input logic [31:0] p, input bit r);
    @(negedge CLK);
    in_valid = v;
    in_flit.payload = p;
    credit_return = r;
    @(posedge CLK);
    #1;
    model_edge();
    check_all();
  endtask
  task automatic do_reset();
    RST = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    in_valid = 1'b0;
    credit_return = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask
  initial begin
    logic [31:0] p;
    bit v, r;
    model_reset();
    #12;
    check_all();
    @(negedge CLK);
    RST = 1'b0;
    step(0, 32'h0, 1);
    step(0, 32'h0, 0);
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 32'hA000_0000 + 32'(i << 4) + 32'h1, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 0);
    step(0, 32'h0, 1);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'hB000_0004 + 32'(i << 8), 0);
    step(0, 32'h0, 0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      p = $urandom();
      p[3:0] = 4'($urandom_range(0, 4));
      v = $urandom_range(0, 99) < 60;
      r = (m_cr <= 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
      step(v, p, r);
      if ($urandom_range(0, 399) == 0) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/credit_tx_port.md
Name: credit_tx_port

Overview:
- Switch output-port transmitter: drives flits across a link into a downstream input-buffer bank and tracks free downstream FIFO space with credits.
- Sits between crossbar output and link.
- Downstream buffer returns one `credit_return` pulse per 3*DEPTH/4 flits drained; this block converts those pulses into credits.
- Tracks packet boundaries via `expected_num_flits()` (chiplet_types_pkg) so `pkt_active` reports an in-flight packet.

Parameters:
DEPTH, 8, downstream buffer FIFO depth; initial credit count.
CREDIT_CHUNK, 3*DEPTH/4, credits restored per credit_return pulse.
TX_DEPTH, 4, local staging FIFO entries.

Ports:
CLK  input  1  clock.
RST  input  1  asynchronous, active-high reset.
in_valid  input  1  crossbar presents a flit.
in_ready  output  1  staging FIFO not full; flit accepted when in_valid && in_ready.
in_flit  input  flit_t  flit from crossbar.
credit_return  input  1  one-cycle pulse: downstream freed CREDIT_CHUNK entries.
out_wen  output  1  registered write enable to downstream buffer (its WEN).
out_flit  output  flit_t  registered flit to downstream buffer (its wdata).
credits  output  $clog2(DEPTH+1)  current credit count.
pkt_active  output  1  mid-packet (head sent, tail not yet sent).
credit_err  output  1  sticky: credit count would exceed DEPTH.

Behaviour:
- Reset (RST high, async): credits=DEPTH; staging FIFO empty; out_wen=0; out_flit='0; pkt_active=0; credit_err=0; state IDLE; remaining='0.
- Staging FIFO: socetlib_fifo of flit_t, TX_DEPTH entries.
  - in_ready = !full.
  - Push on in_valid && in_ready; push when full is impossible.
- Send condition: `send = !empty && credits != 0`.
  - On send: pop head entry; next cycle out_wen=1, out_flit=popped flit.
  - Otherwise next cycle out_wen=0 and out_flit holds.
  - Latency: flit pushed into an empty FIFO with credits>0 appears on out_flit 2 cycles after the accepting edge (1 cycle FIFO, 1 cycle output register).
  - Back-to-back sends sustain 1 flit/cycle while credits and data last.
- Credit arithmetic, next = credits - send + (credit_return ? CREDIT_CHUNK : 0):
  - Computed at one bit wider than credits.
  - If next > DEPTH: saturate at DEPTH, set credit_err (cleared only by RST).
  - Simultaneous send and credit_return apply together in one cycle.
  - Credits never go below 0; send is blocked at 0.
- Packet FSM:
  - IDLE: on send, load remaining = expected_num_flits(flit.payload) - 1.
    - If the result is 0 (single-flit packet), stay IDLE.
    - Else go to ACTIVE with pkt_active=1 (registered, same edge as out_wen).
  - ACTIVE: on send, remaining decrements.
    - When send occurs with remaining==1, go to IDLE and clear pkt_active.
  - A credit stall (credits==0) mid-packet holds ACTIVE; no flits are dropped or reordered.
- Ordering: strict FIFO; no flit is ever sent without a credit.
- RST mid-packet: all state returns to reset values; the partially sent packet is abandoned; downstream recovery is out of scope.
- Simulation only: $warning on FIFO overrun/underrun, matching the switch-buffer convention.

Test Plan:
- Reset then push 8 single-flit packets back-to-back (DEPTH=8) -> 8 consecutive out_wen cycles starting 2 cycles after the first push; credits 8→0; a 9th flit is held; in_ready stays 1 until the FIFO fills (4 entries).
- Credits=0 with 3 flits staged, pulse credit_return -> credits=6; 3 flits sent on the next 3 cycles; credits end at 3.
- Credits=2 with flits staged, credit_return in the same cycle as a send -> credits=2-1+6=7 next cycle.
- Credits=8 (idle), pulse credit_return -> credits stays 8; credit_err=1 and persists until RST.
- 4-flit packet (expected_num_flits=4) with credits=2 -> 2 flits, pkt_active=1 through the stall; after credit_return, 2 more flits; pkt_active drops with the tail's out_wen cycle +1 edge; total out_wen count=4.
- Assert RST mid-packet with flits staged -> out_wen=0, pkt_active=0, credits=8, in_ready=1 immediately (async); the next head flit restarts the FSM cleanly.
